// File: rtl/jzjpcc_sram_portb_arbiter.sv
// Port B arbiter for the core's dual-port SRAM: requester 0 (data memory) vs requester 1 (loader).
// Optional anti-starvation for requester 1 when JZJPCC_SRAM_ARB_ANTISTARVE_EN is defined.
module jzjpcc_sram_portb_arbiter #(
   parameter int unsigned RAM_A_WIDTH  = 12,
   parameter int unsigned LOCK_MAX     = 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                   clock,
   input  logic                   nReset,
   input  logic                   req0,
   output logic                   ready0,
   input  logic [RAM_A_WIDTH-1:0] addr0,
   input  logic                   we0,
   input  logic [3:0]             mask0,
   input  logic [31:0]            wdata0,
   output logic                   rvalid0,
   output logic [31:0]            rdata0,
   input  logic                   req1,
   output logic                   ready1,
   input  logic [RAM_A_WIDTH-1:0] addr1,
   input  logic                   we1,
   input  logic [3:0]             mask1,
   input  logic [31:0]            wdata1,
   output logic                   rvalid1,
   output logic [31:0]            rdata1,
   input  logic                   lock1,
   output logic [RAM_A_WIDTH-1:0] sramAddressB,
   output logic                   sramWriteEnableB,
   output logic [3:0]             sramByteWriteMaskB,
   output logic [31:0]            sramWriteB,
   input  logic [31:0]            sramReadB
);

   localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
   localparam logic [CntW-1:0] LockMaxC = CntW'(LOCK_MAX);
   localparam bit LockEn = (LOCK_MAX > 1);

   typedef enum logic [0:0] {StArb, StLock1} state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        lock_cnt_q, lock_cnt_d, lock_cnt_inc;
   logic [RAM_A_WIDTH-1:0] addr_q;
   logic                   rvalid0_q, rvalid1_q;
   logic                   grant0_c, grant1_c, grant0, grant1;
   logic                   force1;

`ifdef JZJPCC_SRAM_ARB_ANTISTARVE_EN
   localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);
   localparam logic [StW-1:0] StarveMaxC = StW'(STARVE_LIMIT);

   logic [StW-1:0] starve_q, starve_d;

   assign force1 = (state_q == StArb) && req1 && (starve_q == StarveMaxC);

   // Counts only ARB cycles where requester 1 waits; any transfer or idle cycle clears it.
   always_comb begin
      starve_d = '0;
      if ((state_q == StArb) && req1 && !grant1_c) begin
         starve_d = (starve_q == StarveMaxC) ? starve_q : starve_q + StW'(1);
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force1 = 1'b0;
`endif

   assign lock_cnt_inc = lock_cnt_q + CntW'(1);

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      grant0_c   = 1'b0;
      grant1_c   = 1'b0;
      unique case (state_q)
         StArb: begin
            if (force1) begin
               grant1_c = req1;
            end else begin
               grant0_c = req0;
               grant1_c = req1 && !req0;
            end
            if (LockEn && grant1_c && lock1) begin
               state_d    = StLock1;
               lock_cnt_d = CntW'(1);
            end
         end
         StLock1: begin
            grant1_c = req1;
            if (!req1) begin
               state_d    = StArb;
               lock_cnt_d = '0;
            end else if (!lock1 || (lock_cnt_inc == LockMaxC)) begin
               state_d    = StArb;
               lock_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_cnt_inc;
            end
         end
         default: begin
            state_d    = StArb;
            lock_cnt_d = '0;
         end
      endcase
   end

   // Grants are forced low while reset is held so no beat or write leaks out.
   assign grant0 = grant0_c && nReset;
   assign grant1 = grant1_c && nReset;
   assign ready0 = grant0;
   assign ready1 = grant1;

   assign sramAddressB       = grant0 ? addr0 : (grant1 ? addr1 : addr_q);
   assign sramWriteEnableB   = (grant0 && we0) || (grant1 && we1);
   assign sramByteWriteMaskB = grant1 ? mask1 : mask0;
   assign sramWriteB         = grant1 ? wdata1 : wdata0;

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = sramReadB;
   assign rdata1  = sramReadB;

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q    <= StArb;
         lock_cnt_q <= '0;
         addr_q     <= '0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         addr_q     <= sramAddressB;
         rvalid0_q  <= grant0 && !we0;
         rvalid1_q  <= grant1 && !we1;
      end
   end

endmodule

// File: tb/tb_jzjpcc_sram_portb_arbiter.sv
// Self-checking bench for jzjpcc_sram_portb_arbiter: directed steps then random traffic
// against a behavioural grant/memory model, with a registered-read SRAM model on port B.
module tb_jzjpcc_sram_portb_arbiter;

   localparam int unsigned AW = 12;
   localparam int unsigned LM = 4;
   localparam int unsigned SL = 2;

   logic          clock = 1'b0;
   logic          nReset;
   logic          req0, we0, req1, we1, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [3:0]    mask0, mask1;
   logic [31:0]   wdata0, wdata1;
   logic          ready0, ready1, rvalid0, rvalid1;
   logic [31:0]   rdata0, rdata1;
   logic [AW-1:0] sramAddressB;
   logic          sramWriteEnableB;
   logic [3:0]    sramByteWriteMaskB;
   logic [31:0]   sramWriteB, sramReadB;

   jzjpcc_sram_portb_arbiter #(
      .RAM_A_WIDTH (AW),
      .LOCK_MAX    (LM),
      .STARVE_LIMIT(SL)
   ) dut (
      .clock             (clock),
      .nReset            (nReset),
      .req0              (req0),
      .ready0            (ready0),
      .addr0             (addr0),
      .we0               (we0),
      .mask0             (mask0),
      .wdata0            (wdata0),
      .rvalid0           (rvalid0),
      .rdata0            (rdata0),
      .req1              (req1),
      .ready1            (ready1),
      .addr1             (addr1),
      .we1               (we1),
      .mask1             (mask1),
      .wdata1            (wdata1),
      .rvalid1           (rvalid1),
      .rdata1            (rdata1),
      .lock1             (lock1),
      .sramAddressB      (sramAddressB),
      .sramWriteEnableB  (sramWriteEnableB),
      .sramByteWriteMaskB(sramByteWriteMaskB),
      .sramWriteB        (sramWriteB),
      .sramReadB         (sramReadB)
   );

   always #5 clock = ~clock;

   // Port B SRAM: byte-masked write, registered read.
   logic [31:0] sram [0:(1<<AW)-1];
   always @(posedge clock) begin
      if (sramWriteEnableB) begin
         for (int k = 0; k < 4; k++) begin
            if (sramByteWriteMaskB[k]) sram[sramAddressB][k*8 +: 8] <= sramWriteB[k*8 +: 8];
         end
      end
      sramReadB <= sram[sramAddressB];
   end

   // Reference model state
   logic [31:0]   exp_mem [0:(1<<AW)-1];
   bit            m_lock;
   int            m_beats, m_starve;
   logic [AW-1:0] m_addr;
   bit            e_rv0, e_rv1;
   logic [31:0]   e_rdata;
   int            n_vec, n_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_lock = 0; m_beats = 0; m_starve = 0; m_addr = '0; e_rv0 = 0; e_rv1 = 0;
   endtask

   task automatic drive(input bit r0, input bit w0, input int a0, input logic [3:0] m0,
                        input logic [31:0] d0, input bit r1, input bit w1, input int a1,
                        input logic [3:0] m1, input logic [31:0] d1, input bit l1);
      req0 = r0; we0 = w0; addr0 = AW'(a0); mask0 = m0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = AW'(a1); mask1 = m1; wdata1 = d1; lock1 = l1;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0);
   endtask

   // Check everything the model predicts for this cycle, advance the model, move to next negedge.
   task automatic cycle();
      bit g0, g1, was_locked, starve_go;
      logic [AW-1:0] ea;
      logic [31:0]   wd;
      logic [3:0]    wm;
      g0 = 0; g1 = 0;
      starve_go = 0;
`ifdef JZJPCC_SRAM_ARB_ANTISTARVE_EN
      starve_go = (m_starve >= int'(SL)) && req1;
`endif
      if (nReset) begin
         if (m_lock) g1 = req1;
         else if (starve_go) g1 = req1;
         else begin g0 = req0; g1 = req1 && !req0; end
      end
      ea = g0 ? addr0 : (g1 ? addr1 : m_addr);
      wd = g1 ? wdata1 : wdata0;
      wm = g1 ? mask1 : mask0;
      chk("ready0", ready0, g0);
      chk("ready1", ready1, g1);
      chk("sram_we", sramWriteEnableB, (g0 && we0) || (g1 && we1));
      chk("sram_addr", sramAddressB, ea);
      if ((g0 && we0) || (g1 && we1)) begin
         chk("sram_mask", sramByteWriteMaskB, wm);
         chk("sram_wdata", sramWriteB, wd);
      end
      chk("rvalid0", rvalid0, e_rv0);
      chk("rvalid1", rvalid1, e_rv1);
      if (e_rv0) chk("rdata0", rdata0, e_rdata);
      if (e_rv1) chk("rdata1", rdata1, e_rdata);
      if (nReset) begin
         was_locked = m_lock;
         e_rv0 = g0 && !we0;
         e_rv1 = g1 && !we1;
         e_rdata = exp_mem[ea];
         if ((g0 && we0) || (g1 && we1)) begin
            for (int k = 0; k < 4; k++) if (wm[k]) exp_mem[ea][k*8 +: 8] = wd[k*8 +: 8];
         end
         m_addr = ea;
         if (m_lock) begin
            if (!req1) m_lock = 0;
            else begin
               m_beats++;
               if (!lock1 || m_beats >= int'(LM)) m_lock = 0;
            end
         end else if (g1 && lock1 && LM > 1) begin
            m_lock = 1;
            m_beats = 1;
         end
         if (!was_locked && req1 && !g1) m_starve = (m_starve < int'(SL)) ? m_starve + 1 : int'(SL);
         else m_starve = 0;
      end
      @(negedge clock);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      for (int i = 0; i < (1 << AW); i++) begin sram[i] = 32'h0; exp_mem[i] = 32'h0; end
      nReset = 0;
      model_reset();
      @(negedge clock);
      idle();
      chk("rst_ready0", ready0, 1'b0);
      chk("rst_rvalid0", rvalid0, 1'b0);
      chk("rst_we", sramWriteEnableB, 1'b0);
      chk("rst_addr", sramAddressB, '0);
      cycle();
      nReset = 1;
      idle();
      cycle();
      idle();
      chk("idle_ready1", ready1, 1'b0);
      chk("idle_rvalid1", rvalid1, 1'b0);
      chk("idle_addr", sramAddressB, '0);
      cycle();

      // Requester 0 write then read
      drive(1, 1, 'h000, 4'hF, 32'hDEADBEEF, 0, 0, 0, 4'h0, 32'h0, 0);
      cycle();
      drive(1, 0, 'h000, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0);
      cycle();
      idle();
      chk("wr_rd_rvalid0", rvalid0, 1'b1);
      chk("wr_rd_rdata0", rdata0, 32'hDEADBEEF);
      chk("wr_rd_rvalid1", rvalid1, 1'b0);
      cycle();

      // Requester 1 byte-masked write over zero
      drive(0, 0, 0, 4'h0, 32'h0, 1, 1, 'h010, 4'b0101, 32'h11223344, 0);
      cycle();
      drive(0, 0, 0, 4'h0, 32'h0, 1, 0, 'h010, 4'h0, 32'h0, 0);
      cycle();
      idle();
      chk("mask_rvalid1", rvalid1, 1'b1);
      chk("mask_rdata1", rdata1, 32'h00220044);
      cycle();

      // Contention for three cycles
      for (int c = 0; c < 3; c++) begin
         drive(1, 0, 'h001, 4'h0, 32'h0, 1, 0, 'h002, 4'h0, 32'h0, 0);
`ifdef JZJPCC_SRAM_ARB_ANTISTARVE_EN
         chk("contend_ready1", ready1, (c == 2));
`else
         chk("contend_ready1", ready1, 1'b0);
         chk("contend_ready0", ready0, 1'b1);
`endif
         cycle();
      end
      idle();
      cycle();

      // Lock burst: beat 1 alone, then req0 joins; r1 keeps beats 1..4
      drive(0, 0, 'h003, 4'h0, 32'h0, 1, 0, 'h020, 4'h0, 32'h0, 1);
      chk("lock_beat1", ready1, 1'b1);
      cycle();
      for (int b = 2; b <= 6; b++) begin
         drive(1, 0, 'h003, 4'h0, 32'h0, 1, 0, 'h020 + b, 4'h0, 32'h0, 1);
         if (b <= 4) chk("lock_beat_r1", ready1, 1'b1);
         else chk("lock_after_r0", ready0, 1'b1);
         cycle();
      end
      idle();
      cycle();

      // Async reset with a read in flight and the lock held
      drive(0, 0, 0, 4'h0, 32'h0, 1, 0, 'h010, 4'h0, 32'h0, 1);
      cycle();
      #2;
      nReset = 0;
      model_reset();
      idle();
      chk("rst_drop_rvalid1", rvalid1, 1'b0);
      cycle();
      nReset = 1;
      drive(1, 0, 'h004, 4'h0, 32'h0, 1, 0, 'h005, 4'h0, 32'h0, 0);
      chk("rst_release_ready0", ready0, 1'b1);
      chk("rst_release_ready1", ready1, 1'b0);
      cycle();

      // Random traffic over a small address window
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) < 2) begin
            #2;
            nReset = 0;
            model_reset();
         end else if (!nReset) begin
            nReset = 1;
         end
         drive($urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
               4'($urandom), $urandom,
               $urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
               4'($urandom), $urandom, $urandom_range(0, 99) < 65);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
